// File: rtl/ram_arbiter.sv
`timescale 1ns/1ps
// ram_arbiter: shares one single-port synchronous RAM between the core and a
// DMA/debug requester. One access per cycle. The core is favoured by default.
// A starvation counter forces a DMA slot after a run of core grants, and a
// bounded burst lock lets DMA take consecutive slots without locking out the core.
module ram_arbiter #(
    parameter int unsigned AW           = 10,
    parameter int unsigned DW           = 16,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned BURST_MAX    = 8
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,

    input  logic          dma_req,
    input  logic          dma_we,
    input  logic          dma_lock,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,

    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_write,
    input  logic [DW-1:0] ram_dout
);

    localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned BCW = $clog2(BURST_MAX + 1);

    localparam logic [SCW-1:0] STARVE_LAST = SCW'(STARVE_LIMIT - 1);
    localparam logic [SCW-1:0] STARVE_SAT  = SCW'(STARVE_LIMIT);
    localparam logic [BCW-1:0] BURST_LAST  = BCW'(BURST_MAX - 1);

    typedef enum logic {
        S_CORE,
        S_DMA
    } state_t;

    state_t         state_q, state_d;
    logic [SCW-1:0] starve_cnt_q, starve_cnt_d;
    logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
    logic           core_rvalid_q;
    logic           dma_rvalid_q;

    // Grant decode: priority follows the state; nothing is granted while in reset.
    always_comb begin
        core_gnt = 1'b0;
        dma_gnt  = 1'b0;
        if (rst_n) begin
            if (state_q == S_CORE) begin
                core_gnt = core_req;
                dma_gnt  = dma_req & ~core_req;
            end else begin
                dma_gnt  = dma_req;
                core_gnt = core_req & ~dma_req;
            end
        end
    end

    // RAM port mux: granted master drives the RAM; idle cycles park on the core address.
    always_comb begin
        ram_addr  = core_addr;
        ram_din   = core_wdata;
        ram_write = 1'b0;
        if (dma_gnt) begin
            ram_addr  = dma_addr;
            ram_din   = dma_wdata;
            ram_write = dma_we;
        end else if (core_gnt) begin
            ram_write = core_we;
        end
    end

    // Next-state logic for the priority FSM and its starvation/burst counters.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        unique case (state_q)
            S_CORE: begin
                if (dma_gnt || !dma_req) begin
                    starve_cnt_d = '0;
                end else if (core_gnt && (starve_cnt_q != STARVE_SAT)) begin
                    starve_cnt_d = starve_cnt_q + SCW'(1);
                end

                if (core_gnt && dma_req && (starve_cnt_q == STARVE_LAST)) begin
                    // Forced slot: DMA wins next cycle, no DMA grant taken yet.
                    state_d      = S_DMA;
                    starve_cnt_d = '0;
                    burst_cnt_d  = '0;
                end else if (dma_gnt && dma_lock && (BURST_MAX > 1)) begin
                    // Burst start: the grant just taken in S_CORE is the first
                    // of the burst, so the burst count starts at one, keeping the
                    // total run of consecutive DMA grants at BURST_MAX.
                    state_d      = S_DMA;
                    starve_cnt_d = '0;
                    burst_cnt_d  = BCW'(1);
                end
            end
            S_DMA: begin
                if (!dma_req) begin
                    state_d      = S_CORE;
                    starve_cnt_d = '0;
                    burst_cnt_d  = '0;
                end else if (dma_gnt) begin
                    if (dma_lock && (burst_cnt_q < BURST_LAST)) begin
                        burst_cnt_d = burst_cnt_q + BCW'(1);
                    end else begin
                        state_d      = S_CORE;
                        starve_cnt_d = '0;
                        burst_cnt_d  = '0;
                    end
                end
            end
            default: begin
                state_d      = S_CORE;
                starve_cnt_d = '0;
                burst_cnt_d  = '0;
            end
        endcase
    end

    // FSM and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_CORE;
            starve_cnt_q <= '0;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    // Read-return flags: one cycle after a granted read, aligned with RAM data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            core_rvalid_q <= 1'b0;
            dma_rvalid_q  <= 1'b0;
        end else begin
            core_rvalid_q <= core_gnt & ~core_we;
            dma_rvalid_q  <= dma_gnt & ~dma_we;
        end
    end

    assign core_rvalid = core_rvalid_q;
    assign dma_rvalid  = dma_rvalid_q;
    assign core_rdata  = ram_dout;
    assign dma_rdata   = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for ram_arbiter: stimulus pushes per-cycle grant/write
// expectations and expected read data; a negedge monitor pops and compares.
module tb_ram_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 16;

    localparam logic [1:0] G_N = 2'b00;  // {dma_gnt, core_gnt}
    localparam logic [1:0] G_C = 2'b01;
    localparam logic [1:0] G_D = 2'b10;

    typedef struct packed {
        logic [1:0] gnt;
        logic       wr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          core_req, core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_gnt, core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          dma_req, dma_we, dma_lock;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt, dma_rvalid;
    logic [DW-1:0] dma_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_write;
    logic [DW-1:0] ram_dout;

    exp_t          exp_q[$];
    logic [DW-1:0] core_rd_q[$];
    logic [DW-1:0] dma_rd_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            stim_done = 1'b0;

    ram_arbiter #(
        .AW(AW),
        .DW(DW),
        .STARVE_LIMIT(4),
        .BURST_MAX(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .core_req(core_req),
        .core_we(core_we),
        .core_addr(core_addr),
        .core_wdata(core_wdata),
        .core_gnt(core_gnt),
        .core_rvalid(core_rvalid),
        .core_rdata(core_rdata),
        .dma_req(dma_req),
        .dma_we(dma_we),
        .dma_lock(dma_lock),
        .dma_addr(dma_addr),
        .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt),
        .dma_rvalid(dma_rvalid),
        .dma_rdata(dma_rdata),
        .ram_addr(ram_addr),
        .ram_din(ram_din),
        .ram_write(ram_write),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // RAM model: synchronous read-before-write, preloaded on the first edge.
    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 5) return 16'h1234;
        return 16'h5A00 + 16'(i);
    endfunction

    logic [DW-1:0] mem [0:(1<<AW)-1];
    bit            mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (ram_write) begin
            mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr];
    end

    // Monitor: per-cycle grant/write check and read-data scoreboard.
    always @(negedge clk) begin
        exp_t          e;
        logic [DW-1:0] d;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({dma_gnt, core_gnt} !== e.gnt || ram_write !== e.wr) begin
                n_bad++;
                $display("FAIL grant @%0t: got {dma,core}_gnt=%b ram_write=%b, expected %b / %b",
                         $time, {dma_gnt, core_gnt}, ram_write, e.gnt, e.wr);
            end
        end
        if (core_rvalid) begin
            n_cmp++;
            if (core_rd_q.size() == 0) begin
                n_bad++;
                $display("FAIL core_rvalid @%0t: got unexpected rvalid (rdata=%h), expected none",
                         $time, core_rdata);
            end else begin
                d = core_rd_q.pop_front();
                if (core_rdata !== d) begin
                    n_bad++;
                    $display("FAIL core_rdata @%0t: got %h, expected %h", $time, core_rdata, d);
                end
            end
        end
        if (dma_rvalid) begin
            n_cmp++;
            if (dma_rd_q.size() == 0) begin
                n_bad++;
                $display("FAIL dma_rvalid @%0t: got unexpected rvalid (rdata=%h), expected none",
                         $time, dma_rdata);
            end else begin
                d = dma_rd_q.pop_front();
                if (dma_rdata !== d) begin
                    n_bad++;
                    $display("FAIL dma_rdata @%0t: got %h, expected %h", $time, dma_rdata, d);
                end
            end
        end
        if (stim_done) begin
            n_cmp++;
            if (exp_q.size() != 0 || core_rd_q.size() != 0 || dma_rd_q.size() != 0) begin
                n_bad++;
                $display("FAIL drain: got pending exp=%0d core_rd=%0d dma_rd=%0d, expected 0/0/0",
                         exp_q.size(), core_rd_q.size(), dma_rd_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish within 100000ns");
        $fatal(1);
    end

    task automatic step(input logic [1:0] g, input logic w);
        exp_q.push_back('{gnt: g, wr: w});
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input logic req, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd);
        core_req = req; core_we = we; core_addr = a; core_wdata = wd;
    endtask

    task automatic set_dma(input logic req, input logic we, input logic lock,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd);
        dma_req = req; dma_we = we; dma_lock = lock; dma_addr = a; dma_wdata = wd;
    endtask

    initial begin
        rst_n = 1'b0;
        set_core(1'b0, 1'b0, '0, '0);
        set_dma(1'b0, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        // Reset with requests present: no grants, no write strobe.
        set_core(1'b1, 1'b1, 10'h3FF, 16'hDEAD);
        set_dma(1'b1, 1'b1, 1'b1, 10'h3FE, 16'hDEAD);
        step(G_N, 1'b0);
        step(G_N, 1'b0);
        set_core(1'b0, 1'b0, '0, '0);
        set_dma(1'b0, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b1;
        step(G_N, 1'b0);

        // 1: core read of 0x005 with DMA idle.
        set_core(1'b1, 1'b0, 10'h005, '0);
        core_rd_q.push_back(16'h1234);
        step(G_C, 1'b0);
        set_core(1'b0, 1'b0, '0, '0);
        step(G_N, 1'b0);

        // 2: both held continuously -> C,C,C,C,D repeating.
        set_core(1'b1, 1'b0, 10'h020, '0);
        set_dma(1'b1, 1'b0, 1'b0, 10'h030, '0);
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) begin
                dma_rd_q.push_back(16'h5A30);
                step(G_D, 1'b0);
            end else begin
                core_rd_q.push_back(16'h5A20);
                step(G_C, 1'b0);
            end
        end
        set_core(1'b0, 1'b0, '0, '0);
        set_dma(1'b0, 1'b0, 1'b0, '0, '0);
        step(G_N, 1'b0);

        // 3: locked DMA burst of 12 writes, core read arrives at the third write.
        for (int k = 0; k < 8; k++) begin
            set_dma(1'b1, 1'b1, 1'b1, 10'(10'h100 + k), 16'(16'hD000 + k));
            if (k == 2) set_core(1'b1, 1'b0, 10'h050, '0);
            step(G_D, 1'b1);
        end
        set_dma(1'b1, 1'b1, 1'b1, 10'h108, 16'hD008);
        core_rd_q.push_back(16'h5A50);
        step(G_C, 1'b0);
        set_core(1'b0, 1'b0, '0, '0);
        for (int k = 8; k < 12; k++) begin
            set_dma(1'b1, 1'b1, 1'b1, 10'(10'h100 + k), 16'(16'hD000 + k));
            step(G_D, 1'b1);
        end
        set_dma(1'b0, 1'b0, 1'b0, '0, '0);
        step(G_N, 1'b0);
        // Read back all 12 words through single DMA slots.
        for (int k = 0; k < 12; k++) begin
            set_dma(1'b1, 1'b0, 1'b0, 10'(10'h100 + k), '0);
            dma_rd_q.push_back(16'(16'hD000 + k));
            step(G_D, 1'b0);
        end
        set_dma(1'b0, 1'b0, 1'b0, '0, '0);
        step(G_N, 1'b0);

        // 4: same-address collision, core write wins, DMA read sees it next cycle.
        set_core(1'b1, 1'b1, 10'h010, 16'hBEEF);
        set_dma(1'b1, 1'b0, 1'b0, 10'h010, '0);
        step(G_C, 1'b1);
        set_core(1'b0, 1'b0, '0, '0);
        dma_rd_q.push_back(16'hBEEF);
        step(G_D, 1'b0);
        set_dma(1'b0, 1'b0, 1'b0, '0, '0);
        step(G_N, 1'b0);

        // 5: reset pulse in the middle of a locked DMA read burst.
        set_dma(1'b1, 1'b0, 1'b1, 10'h200, '0);
        dma_rd_q.push_back(16'h5C00);
        step(G_D, 1'b0);
        set_dma(1'b1, 1'b0, 1'b1, 10'h201, '0);
        dma_rd_q.push_back(16'h5C01);
        step(G_D, 1'b0);
        set_dma(1'b1, 1'b0, 1'b1, 10'h202, '0);
        rst_n = 1'b0;
        step(G_N, 1'b0);
        rst_n = 1'b1;
        set_core(1'b1, 1'b0, 10'h050, '0);
        set_dma(1'b1, 1'b0, 1'b0, 10'h202, '0);
        for (int i = 0; i < 4; i++) begin
            core_rd_q.push_back(16'h5A50);
            step(G_C, 1'b0);
        end
        dma_rd_q.push_back(16'h5C02);
        step(G_D, 1'b0);
        set_core(1'b0, 1'b0, '0, '0);
        set_dma(1'b0, 1'b0, 1'b0, '0, '0);
        step(G_N, 1'b0);

        // 6: 20 idle cycles, then core still favoured.
        for (int i = 0; i < 20; i++) step(G_N, 1'b0);
        set_core(1'b1, 1'b1, 10'h300, 16'h1111);
        set_dma(1'b1, 1'b0, 1'b0, 10'h300, '0);
        step(G_C, 1'b1);
        set_core(1'b0, 1'b0, '0, '0);
        dma_rd_q.push_back(16'h1111);
        step(G_D, 1'b0);
        set_dma(1'b0, 1'b0, 1'b0, '0, '0);
        step(G_N, 1'b0);
        step(G_N, 1'b0);
        stim_done = 1'b1;
    end

endmodule
